// File: rtl/mult_accum_pkg.sv
// Shared types for the mult_accum sequencer: FSM state encoding and MAC defaults.
package mult_accum_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    CAPT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int MAC_LATENCY_DEF = 3;

  // Width of the drain counter; it must reach mac_latency.
  function automatic int dcnt_bits(input int lat);
    return $clog2(lat + 2);
  endfunction

endpackage

// File: rtl/mult_accum_seq_cnt.sv
// Saturating beat counter with clear, load-to-one and increment.
module mult_accum_seq_cnt
  import mult_accum_pkg::*;
#(
  parameter int cnt_width = 8
) (
  input  logic                 clock0,
  input  logic                 aclr0,
  input  logic                 i_clr,
  input  logic                 i_load1,
  input  logic                 i_inc,
  output logic [cnt_width-1:0] o_cnt,
  output logic                 o_sat
);

  logic [cnt_width-1:0] r_cnt;
  logic                 r_sat;

  // Sticky saturation flags an increment attempted while already at all-ones.
  always_ff @(posedge clock0) begin
    if (aclr0 || i_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_load1) begin
      r_cnt <= cnt_width'(1);
      r_sat <= 1'b0;
    end else if (i_inc) begin
      if (&r_cnt) begin
        r_sat <= 1'b1;
      end else begin
        r_cnt <= r_cnt + cnt_width'(1);
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

// File: rtl/mult_accum_seq.sv
// Operand sequencer and result capture for the mult_accum MAC: one dot product per vector,
// drained through the MAC pipeline and presented on a valid/ready output.
module mult_accum_seq
  import mult_accum_pkg::*;
#(
  parameter int width_a      = 8,
  parameter int width_b      = 8,
  parameter int width_result = 24,
  parameter int mac_latency  = MAC_LATENCY_DEF,
  parameter int cnt_width    = 8
) (
  input  logic                    clock0,
  input  logic                    aclr0,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [width_a-1:0]      in_a,
  input  logic [width_b-1:0]      in_b,
  input  logic                    in_last,
  output logic [width_a-1:0]      dataa,
  output logic [width_b-1:0]      datab,
  output logic                    accum_sload,
  output logic                    ena0,
  input  logic [width_result-1:0] result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width_result-1:0] out_data,
  output logic [cnt_width-1:0]    out_count,
  output logic                    out_cnt_sat
);

  localparam int DW = dcnt_bits(mac_latency);
  localparam logic [DW-1:0] DCNT_LAST = DW'(mac_latency);

  state_t                  r_state;
  logic [DW-1:0]           r_dcnt;
  logic [width_a-1:0]      r_dataa;
  logic [width_b-1:0]      r_datab;
  logic                    r_sload;
  logic                    r_ena0;
  logic                    r_out_valid;
  logic [width_result-1:0] r_out_data;
  logic [cnt_width-1:0]    r_out_count;
  logic                    r_out_cnt_sat;

  logic                    w_ready;
  logic                    w_beat;
  logic                    w_done;
  logic [cnt_width-1:0]    w_cnt;
  logic                    w_sat;

  assign w_ready = (r_state == IDLE) || (r_state == FEED);
  assign w_beat  = in_valid && w_ready;
  assign w_done  = (r_state == HOLD) && out_ready;

  mult_accum_seq_cnt #(
    .cnt_width (cnt_width)
  ) u_cnt (
    .clock0  (clock0),
    .aclr0   (aclr0),
    .i_clr   (w_done),
    .i_load1 (w_beat && (r_state == IDLE)),
    .i_inc   (w_beat && (r_state == FEED)),
    .o_cnt   (w_cnt),
    .o_sat   (w_sat)
  );

  // ena0/sload default low so bubbles and idle cycles freeze the MAC.
  always_ff @(posedge clock0) begin
    if (aclr0) begin
      r_state       <= IDLE;
      r_dcnt        <= '0;
      r_dataa       <= '0;
      r_datab       <= '0;
      r_sload       <= 1'b0;
      r_ena0        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_count   <= '0;
      r_out_cnt_sat <= 1'b0;
    end else begin
      r_ena0  <= 1'b0;
      r_sload <= 1'b0;
      case (r_state)
        IDLE, FEED: begin
          if (w_beat) begin
            r_dataa <= in_a;
            r_datab <= in_b;
            r_ena0  <= 1'b1;
            r_sload <= (r_state == IDLE);
            r_dcnt  <= '0;
            r_state <= in_last ? DRAIN : FEED;
          end else begin
            r_state <= r_state;
          end
        end
        DRAIN: begin
          // Zero operands flush the pipe while adding nothing to the sum.
          r_ena0  <= 1'b1;
          r_dataa <= '0;
          r_datab <= '0;
          if (r_dcnt == DCNT_LAST) begin
            r_state <= CAPT;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        CAPT: begin
          r_out_data    <= result;
          r_out_count   <= w_cnt;
          r_out_cnt_sat <= w_sat;
          r_out_valid   <= 1'b1;
          r_state       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = w_ready;
  assign dataa       = r_dataa;
  assign datab       = r_datab;
  assign accum_sload = r_sload;
  assign ena0        = r_ena0;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_count   = r_out_count;
  assign out_cnt_sat = r_out_cnt_sat;

endmodule
